fix_conn_scheduler: RTL

FIX_CONN_SCHEDULER -- requirements
Module: fix_conn_scheduler

---
 rtl/fix_conn_scheduler_if.sv | 28 ++
 rtl/fix_conn_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fix_conn_scheduler_if.sv
// Bundle between the connection scheduler, the application host requests and the TOE command port.
// master: scheduler side; slave: application/TOE side.
interface fix_conn_scheduler_if;
    logic [3:0] connect_i;
    logic [3:0] disconnect_i;
    logic       toe_ready_i;
    logic       connected_i;
    logic [1:0] connected_host_addr_i;
    logic       connect_req_o;
    logic [1:0] connect_addr_o;
    logic       disconnect_o;
    logic [1:0] disconnect_host_num_o;
    logic [3:0] host_up_o;
    logic [3:0] fail_o;
    logic       busy_o;

    modport master (
        input  connect_i, disconnect_i, toe_ready_i, connected_i, connected_host_addr_i,
        output connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
        output host_up_o, fail_o, busy_o
    );

    modport slave (
        output connect_i, disconnect_i, toe_ready_i, connected_i, connected_host_addr_i,
        input  connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
        input  host_up_o, fail_o, busy_o
    );
endinterface

// File: rtl/fix_conn_scheduler.sv
// Round-robin connect/disconnect scheduler for four hosts in front of a TOE command port.
// Define FIX_CONN_RETRY_EN to re-issue timed-out connects up to MAX_RETRY times before failing.
module fix_conn_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fix_conn_scheduler_if.master bus
);

    localparam int unsigned N_HOSTS = 4;
    localparam int unsigned HOST_W  = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RETRY_W = 3;

`ifdef FIX_CONN_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t              state;
    logic [HOST_W-1:0]   host;
    logic [HOST_W-1:0]   rr_ptr;
    logic                op_disc;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [RETRY_W-1:0]  retry_cnt;

    logic [N_HOSTS-1:0]  need_c;
    logic [N_HOSTS-1:0]  disc_c;
    logic                sel_valid_c;
    logic [HOST_W-1:0]   sel_host_c;
    logic [HOST_W-1:0]   idx_c;
    logic                ack_match_c;
    logic                tmo_hit_c;

    // First needy host at or after rr_ptr; iterate backwards so the nearest offset wins.
    always_comb begin
        disc_c      = bus.disconnect_i & bus.host_up_o;
        need_c      = (bus.connect_i & ~bus.host_up_o & ~bus.fail_o) | disc_c;
        sel_valid_c = 1'b0;
        sel_host_c  = rr_ptr;
        idx_c       = rr_ptr;
        for (int i = int'(N_HOSTS) - 1; i >= 0; i--) begin
            idx_c = rr_ptr + HOST_W'(i);
            if (need_c[idx_c]) begin
                sel_valid_c = 1'b1;
                sel_host_c  = idx_c;
            end
        end
        ack_match_c = bus.connected_i && (bus.connected_host_addr_i == host);
        tmo_hit_c   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            host                      <= '0;
            rr_ptr                    <= '0;
            op_disc                   <= 1'b0;
            tmo_cnt                   <= '0;
            retry_cnt                 <= '0;
            bus.connect_req_o         <= 1'b0;
            bus.connect_addr_o        <= '0;
            bus.disconnect_o          <= 1'b0;
            bus.disconnect_host_num_o <= '0;
            bus.host_up_o             <= '0;
            bus.fail_o                <= '0;
            bus.busy_o                <= 1'b0;
        end else begin
            bus.connect_req_o         <= 1'b0;
            bus.connect_addr_o        <= '0;
            bus.disconnect_o          <= 1'b0;
            bus.disconnect_host_num_o <= '0;
            // A failure is held only while the app keeps requesting that host.
            bus.fail_o                <= bus.fail_o & bus.connect_i;

            case (state)
                IDLE: begin
                    if (sel_valid_c) begin
                        host       <= sel_host_c;
                        op_disc    <= disc_c[sel_host_c];
                        state      <= ISSUE;
                        bus.busy_o <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (bus.toe_ready_i) begin
                        if (op_disc) begin
                            bus.disconnect_o          <= 1'b1;
                            bus.disconnect_host_num_o <= host;
                            bus.host_up_o[host]       <= 1'b0;
                            rr_ptr                    <= host + HOST_W'(1);
                            state                     <= IDLE;
                            bus.busy_o                <= 1'b0;
                        end else begin
                            bus.connect_req_o  <= 1'b1;
                            bus.connect_addr_o <= host;
                            tmo_cnt            <= '0;
                            state              <= WAIT_ACK;
                        end
                    end
                end

                WAIT_ACK: begin
                    if (ack_match_c) begin
                        bus.host_up_o[host] <= 1'b1;
                        retry_cnt           <= '0;
                        rr_ptr              <= host + HOST_W'(1);
                        state               <= IDLE;
                        bus.busy_o          <= 1'b0;
                    end else if (tmo_hit_c) begin
                        if (RETRY_EN && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= ISSUE;
                        end else begin
                            bus.fail_o[host] <= 1'b1;
                            retry_cnt        <= '0;
                            rr_ptr           <= host + HOST_W'(1);
                            state            <= IDLE;
                            bus.busy_o       <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
